// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker: walks every {a,b} operand pair once and checks four
// gate-level De Morgan identities on each one. It keeps a failure count, the
// first failing vector, and a pass/fail flag. The inject mask corrupts chosen
// identities on purpose so that the failure path can be exercised.
module demorgan_sweep_checker #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 2*WIDTH+3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       inject,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] cur_a,
   output logic [WIDTH-1:0] cur_b,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] first_fail_a,
   output logic [WIDTH-1:0] first_fail_b,
   output logic [1:0]       first_fail_id,
   output logic             fail_seen
);

   localparam int VW = 2*WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [VW-1:0]   vec;
   logic [3:0]      inj_q;
   logic            start_ok;
   logic            last_vec;

   logic [WIDTH-1:0] nand_ab, neg_or, nor_ab, neg_and;
   logic [WIDTH-1:0] nor_aa, nor_bb, and_nor, nand_aa, nand_bb, or_nand;
   logic [3:0]       mism;
   logic [2:0]       mism_cnt;
   logic [1:0]       low_id;

   // The vector counter is the operand pair itself, with a in the upper half.
   assign cur_a    = vec[VW-1:WIDTH];
   assign cur_b    = vec[WIDTH-1:0];
   assign last_vec = &vec;
   assign start_ok = start && (state == IDLE || state == DONE);

   // Gate network: each identity pits a gate-level build against its reference.
   always_comb begin
      nand_ab = ~(cur_a & cur_b);
      neg_or  = ~cur_a | ~cur_b;
      nor_ab  = ~(cur_a | cur_b);
      neg_and = ~cur_a & ~cur_b;
      nor_aa  = ~(cur_a | cur_a);
      nor_bb  = ~(cur_b | cur_b);
      and_nor = ~(nor_aa | nor_bb);
      nand_aa = ~(cur_a & cur_a);
      nand_bb = ~(cur_b & cur_b);
      or_nand = ~(nand_aa & nand_bb);
      // Injection flips bit 0 of the left-hand side only.
      mism[0] = (nand_ab ^ WIDTH'(inj_q[0])) != neg_or;
      mism[1] = (nor_ab  ^ WIDTH'(inj_q[1])) != neg_and;
      mism[2] = (and_nor ^ WIDTH'(inj_q[2])) != (cur_a & cur_b);
      mism[3] = (or_nand ^ WIDTH'(inj_q[3])) != (cur_a | cur_b);
      mism_cnt = 3'(mism[0]) + 3'(mism[1]) + 3'(mism[2]) + 3'(mism[3]);
   end

   // Lowest failing identity index for the vector currently applied.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      low_id = 2'd0;
      if (mism[0])      low_id = 2'd0;
      else if (mism[1]) low_id = 2'd1;
      else if (mism[2]) low_id = 2'd2;
      else if (mism[3]) low_id = 2'd3;
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_vec) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
      pass = done && (err_count == '0);
   end

   // Sweep datapath: vector counter, error accumulation, first-fail capture.
   // The check for the applied vector retires on the following RUN edge; the
   // last vector retires on the edge that enters DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec           <= '0;
         inj_q         <= '0;
         err_count     <= '0;
         first_fail_a  <= '0;
         first_fail_b  <= '0;
         first_fail_id <= '0;
         fail_seen     <= 1'b0;
      end else if (start_ok) begin
         vec           <= '0;
         inj_q         <= inject;
         err_count     <= '0;
         first_fail_a  <= '0;
         first_fail_b  <= '0;
         first_fail_id <= '0;
         fail_seen     <= 1'b0;
      end else if (state == RUN) begin
         if (!last_vec) vec <= vec + 1'b1;
         err_count <= err_count + CNT_W'(mism_cnt);
         if ((|mism) && !fail_seen) begin
            first_fail_a  <= cur_a;
            first_fail_b  <= cur_b;
            first_fail_id <= low_id;
            fail_seen     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: a WIDTH=1 and a WIDTH=2 instance share
// clock and reset. Expected vectors and end-of-sweep results are queued when
// a sweep is launched and popped as the DUT produces them.
module tb_demorgan_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start;
   logic [3:0] inject;
   int         sel;
   logic       start1, start2;

   assign start1 = start && (sel == 1);
   assign start2 = start && (sel == 2);

   logic       busy1, done1, pass1, fs1;
   logic [0:0] a1, b1, ffa1, ffb1;
   logic [1:0] ffid1;
   logic [4:0] err1;

   logic       busy2, done2, pass2, fs2;
   logic [1:0] a2, b2, ffa2, ffb2;
   logic [1:0] ffid2;
   logic [6:0] err2;

   demorgan_sweep_checker #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .inject(inject),
      .busy(busy1), .done(done1), .pass(pass1), .cur_a(a1), .cur_b(b1),
      .err_count(err1), .first_fail_a(ffa1), .first_fail_b(ffb1),
      .first_fail_id(ffid1), .fail_seen(fs1));

   demorgan_sweep_checker #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .inject(inject),
      .busy(busy2), .done(done2), .pass(pass2), .cur_a(a2), .cur_b(b2),
      .err_count(err2), .first_fail_a(ffa2), .first_fail_b(ffb2),
      .first_fail_id(ffid2), .fail_seen(fs2));

   // View of whichever instance is selected.
   logic       o_busy, o_done, o_pass, o_fs;
   logic [3:0] o_cur;
   logic [6:0] o_err;
   logic [1:0] o_ffa, o_ffb, o_ffid;
   always_comb begin
      o_busy = (sel == 2) ? busy2 : busy1;
      o_done = (sel == 2) ? done2 : done1;
      o_pass = (sel == 2) ? pass2 : pass1;
      o_fs   = (sel == 2) ? fs2   : fs1;
      o_cur  = (sel == 2) ? {a2, b2} : {2'b00, a1, b1};
      o_err  = (sel == 2) ? err2 : {2'b00, err1};
      o_ffa  = (sel == 2) ? ffa2 : {1'b0, ffa1};
      o_ffb  = (sel == 2) ? ffb2 : {1'b0, ffb1};
      o_ffid = (sel == 2) ? ffid2 : ffid1;
   end

   typedef struct {
      int err;
      int pass_v;
      int fs;
      int ffa;
      int ffb;
      int ffid;
   } res_t;

   int   vec_q[$];
   res_t res_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_done"}, 32'(o_done), 0);
      check({tag, "_pass"}, 32'(o_pass), 0);
      check({tag, "_cur"},  32'(o_cur),  0);
      check({tag, "_err"},  32'(o_err),  0);
      check({tag, "_ffa"},  32'(o_ffa),  0);
      check({tag, "_ffb"},  32'(o_ffb),  0);
      check({tag, "_ffid"}, 32'(o_ffid), 0);
      check({tag, "_fs"},   32'(o_fs),   0);
   endtask

   // Launch one sweep on instance w. pulse_at re-pulses start at that vector
   // (with a different mask); rst_at asserts reset at that vector instead of
   // finishing. Entered and left on a falling edge.
   task automatic sweep(input int w, input logic [3:0] inj, input int pulse_at, input int rst_at);
      int   n;
      int   pc;
      int   busy_cycles;
      int   exp_v;
      res_t r;
      n           = 1 << (2*w);
      busy_cycles = 0;
      sel         = w;
      for (int k = 0; k < n; k++) vec_q.push_back(k);
      pc       = int'(inj[0]) + int'(inj[1]) + int'(inj[2]) + int'(inj[3]);
      r.err    = n * pc;
      r.pass_v = (pc == 0) ? 1 : 0;
      r.fs     = (pc != 0) ? 1 : 0;
      r.ffa    = 0;
      r.ffb    = 0;
      r.ffid   = inj[0] ? 0 : inj[1] ? 1 : inj[2] ? 2 : inj[3] ? 3 : 0;
      res_q.push_back(r);

      inject = inj;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      for (int k = 0; k < n; k++) begin
         exp_v = vec_q.pop_front();
         check("cur_vec", 32'(o_cur), 32'(exp_v));
         check("run_done_low", 32'(o_done), 0);
         if (o_busy) busy_cycles++;
         if (k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_zero("mid_rst");
            vec_q.delete();
            r = res_q.pop_front();
            @(negedge clk);
            check("idle_after_rst_busy", 32'(o_busy), 0);
            check("idle_after_rst_done", 32'(o_done), 0);
            return;
         end
         start  = (k == pulse_at);
         inject = (k == pulse_at) ? ~inj : inj;
         @(negedge clk);
         start  = 1'b0;
         inject = inj;
      end
      check("drain_busy", 32'(o_busy), 1);
      check("drain_done", 32'(o_done), 0);
      check("drain_cur",  32'(o_cur),  32'(n-1));
      if (o_busy) busy_cycles++;
      @(negedge clk);
      check("done_high",   32'(o_done), 1);
      check("done_busy",   32'(o_busy), 0);
      check("busy_cycles", 32'(busy_cycles), 32'(n+1));
      r = res_q.pop_front();
      check("err_count", 32'(o_err),  32'(r.err));
      check("pass",      32'(o_pass), 32'(r.pass_v));
      check("fail_seen", 32'(o_fs),   32'(r.fs));
      check("ff_a",      32'(o_ffa),  32'(r.ffa));
      check("ff_b",      32'(o_ffb),  32'(r.ffb));
      check("ff_id",     32'(o_ffid), 32'(r.ffid));
      @(negedge clk);
      check("done_hold",     32'(o_done), 1);
      check("err_hold",      32'(o_err),  32'(r.err));
      check("cur_hold",      32'(o_cur),  32'(n-1));
   endtask

   initial begin
      sel    = 1;
      rst    = 1'b1;
      start  = 1'b0;
      inject = 4'h0;
      @(negedge clk);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      #1;
      check_zero("reset_w1");
      sel = 2;
      #1;
      check_zero("reset_w2");
      @(negedge clk);
      rst = 1'b0;

      sweep(1, 4'b0000, -1, -1);
      sweep(2, 4'b0001, -1, -1);
      sweep(2, 4'b1010, -1, -1);
      sweep(2, 4'b0000,  5, -1);
      sweep(2, 4'b1111, -1,  7);
      sweep(2, 4'b0000, -1, -1);
      sweep(1, 4'b0100, -1, -1);
      sweep(1, 4'b0000, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
